// File: rtl/alu_ctrl_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_stage_if
// Brief    : Decode-side and ALU-side handshake bundle for alu_ctrl_stage.
// Revision : 1.0
// ============================================================================
interface alu_ctrl_stage_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CMD_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   Op_from_control;
  logic [5:0]        fonction;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic              out_valid;
  logic              out_ready;
  logic [CMD_W-1:0]  ctrl_command;
  logic [DATA_W-1:0] outreg1;
  logic [DATA_W-1:0] outreg2;
  logic              out_illegal;

  // Environment side: issues decode bundles and consumes ALU commands.
  modport master (
    output in_valid, Op_from_control, fonction, reg1, reg2, out_ready,
    input  in_ready, out_valid, ctrl_command, outreg1, outreg2, out_illegal
  );

  // Stage side.
  modport slave (
    input  in_valid, Op_from_control, fonction, reg1, reg2, out_ready,
    output in_ready, out_valid, ctrl_command, outreg1, outreg2, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_stage
// Brief    : Decodes opcode/funct into an ALU command and registers it with
//            its operands behind a two-entry (OUT + SKID) valid/ready buffer.
// Revision : 1.0
// ============================================================================
module alu_ctrl_stage #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CMD_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  alu_ctrl_stage_if.slave    bus
);

  localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_MUL = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_AND = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_OR  = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_XOR = CMD_W'(5);
  localparam logic [CMD_W-1:0] CMD_NOR = CMD_W'(6);
  localparam logic [CMD_W-1:0] CMD_SLT = CMD_W'(7);
  localparam logic [CMD_W-1:0] CMD_SLL = CMD_W'(8);
  localparam logic [CMD_W-1:0] CMD_SRL = CMD_W'(9);

  localparam logic [OP_W-1:0] OPC_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OPC_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OPC_MUL   = OP_W'(2);
  localparam logic [OP_W-1:0] OPC_AND   = OP_W'(3);
  localparam logic [OP_W-1:0] OPC_OR    = OP_W'(4);
  localparam logic [OP_W-1:0] OPC_RTYPE = OP_W'(5);

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic              illegal;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           out_q, out_d;
  entry_t           skid_q, skid_d;
  entry_t           in_entry;
  logic [CMD_W-1:0] dec_cmd;
  logic             dec_illegal;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             consume;

  // Unknown opcodes and unknown R-type functs both fall back to ADD, flagged.
  always_comb begin
    dec_cmd     = CMD_ADD;
    dec_illegal = 1'b0;
    case (bus.Op_from_control)
      OPC_ADD:   dec_cmd = CMD_ADD;
      OPC_SUB:   dec_cmd = CMD_SUB;
      OPC_MUL:   dec_cmd = CMD_MUL;
      OPC_AND:   dec_cmd = CMD_AND;
      OPC_OR:    dec_cmd = CMD_OR;
      OPC_RTYPE: begin
        case (bus.fonction)
          FN_ADD:  dec_cmd = CMD_ADD;
          FN_SUB:  dec_cmd = CMD_SUB;
          FN_MUL:  dec_cmd = CMD_MUL;
          FN_AND:  dec_cmd = CMD_AND;
          FN_OR:   dec_cmd = CMD_OR;
          FN_XOR:  dec_cmd = CMD_XOR;
          FN_NOR:  dec_cmd = CMD_NOR;
          FN_SLT:  dec_cmd = CMD_SLT;
          FN_SLL:  dec_cmd = CMD_SLL;
          FN_SRL:  dec_cmd = CMD_SRL;
          default: dec_illegal = 1'b1;
        endcase
      end
      default:   dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    in_entry.cmd     = dec_cmd;
    in_entry.illegal = dec_illegal;
    in_entry.op1     = bus.reg1;
    in_entry.op2     = bus.reg2;
  end

  // Ready and valid come straight from the state register, so out_ready
  // never reaches in_ready combinationally.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = bus.in_valid & in_ready;
  assign consume   = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_d   = in_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          out_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = ST_FULL;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // SKID is always the older entry, so it moves up before any new input.
        if (consume) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.ctrl_command = out_q.cmd;
  assign bus.out_illegal  = out_q.illegal;
  assign bus.outreg1      = out_q.op1;
  assign bus.outreg2      = out_q.op2;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_stage
// Brief    : Directed self-checking bench for alu_ctrl_stage (32- and 64-bit).
// Revision : 1.0
// ============================================================================
module tb_alu_ctrl_stage;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;

  alu_ctrl_stage_if #(.DATA_W(32), .OP_W(4), .CMD_W(4)) bus ();
  alu_ctrl_stage_if #(.DATA_W(64), .OP_W(4), .CMD_W(4)) b64 ();

  alu_ctrl_stage #(.DATA_W(32), .OP_W(4), .CMD_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  alu_ctrl_stage #(.DATA_W(64), .OP_W(4), .CMD_W(4)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input int fn, input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid        = 1'b1;
    bus.Op_from_control = 4'(op);
    bus.fonction        = 6'(fn);
    bus.reg1            = r1;
    bus.reg2            = r2;
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.ctrl_command !== 4'd0) begin errors++; $display("FAIL reset_cmd: got %h expected 0", bus.ctrl_command); end
    checks++; if (bus.outreg1 !== 32'd0 || bus.outreg2 !== 32'd0) begin errors++; $display("FAIL reset_operands: got %h/%h expected 0/0", bus.outreg1, bus.outreg2); end
    checks++; if (bus.out_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", bus.out_illegal); end
    checks++; if (b64.outreg1 !== 64'd0 || b64.out_valid !== 1'b0) begin errors++; $display("FAIL reset_64: got %h valid %b expected 0 valid 0", b64.outreg1, b64.out_valid); end
    #3 rst_n = 1'b1;
    tick;
  endtask

  task automatic test_decode;
    int op_t [17] = '{0, 1, 2, 3, 4, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 9};
    int fn_t [17] = '{0, 0, 0, 0, 0, 'h20, 'h22, 'h18, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h00, 'h02, 'h3F, 0};
    int cmd_t[17] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0};
    int ill_t[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(op_t[i], fn_t[i], 32'(i) + 32'h1000, ~32'(i));
      tick;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.ctrl_command !== 4'(cmd_t[i]) || bus.out_illegal !== 1'(ill_t[i])
          || bus.outreg1 !== 32'(i) + 32'h1000 || bus.outreg2 !== ~32'(i)) begin
        errors++;
        $display("FAIL decode[%0d] op=%0d fn=%h: got v=%b cmd=%0d ill=%b r1=%h r2=%h expected v=1 cmd=%0d ill=%0d r1=%h r2=%h",
                 i, op_t[i], fn_t[i], bus.out_valid, bus.ctrl_command, bus.out_illegal, bus.outreg1, bus.outreg2,
                 cmd_t[i], ill_t[i], 32'(i) + 32'h1000, ~32'(i));
      end
    end
    bus.in_valid = 1'b0;
    tick;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL decode_drain: got valid %b expected 0", bus.out_valid); end
  endtask

  task automatic test_back_pressure;
    bus.out_ready = 1'b0;
    drive(1, 0, 32'd1, 32'd0);
    tick;
    checks++; if (bus.out_valid !== 1'b1 || bus.outreg1 !== 32'd1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_A_loaded: got v=%b r1=%h rdy=%b expected v=1 r1=1 rdy=1", bus.out_valid, bus.outreg1, bus.in_ready); end
    drive(1, 0, 32'd2, 32'd0);
    tick;
    checks++; if (bus.in_ready !== 1'b0 || bus.outreg1 !== 32'd1) begin errors++; $display("FAIL bp_full: got rdy=%b r1=%h expected rdy=0 r1=1", bus.in_ready, bus.outreg1); end
    drive(1, 0, 32'd3, 32'd0);
    tick;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.outreg1 !== 32'd1 || bus.ctrl_command !== 4'd1) begin errors++; $display("FAIL bp_hold: got rdy=%b v=%b r1=%h cmd=%0d expected rdy=0 v=1 r1=1 cmd=1", bus.in_ready, bus.out_valid, bus.outreg1, bus.ctrl_command); end
    bus.out_ready = 1'b1;
    tick;
    checks++; if (bus.outreg1 !== 32'd2 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_B_out: got r1=%h v=%b rdy=%b expected r1=2 v=1 rdy=1", bus.outreg1, bus.out_valid, bus.in_ready); end
    tick;
    checks++; if (bus.outreg1 !== 32'd3 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_C_out: got r1=%h v=%b expected r1=3 v=1", bus.outreg1, bus.out_valid); end
    bus.in_valid = 1'b0;
    tick;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got v=%b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_midstream;
    bus.out_ready = 1'b0;
    drive(1, 0, 32'hAA, 32'hBB);
    tick;
    drive(2, 0, 32'hCC, 32'hDD);
    tick;
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0 || bus.ctrl_command !== 4'd1) begin errors++; $display("FAIL rst_mid_setup: got rdy=%b cmd=%0d expected rdy=0 cmd=1", bus.in_ready, bus.ctrl_command); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ctrl_command !== 4'd0 || bus.outreg1 !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_async: got v=%b rdy=%b cmd=%0d r1=%h expected v=0 rdy=1 cmd=0 r1=0", bus.out_valid, bus.in_ready, bus.ctrl_command, bus.outreg1);
    end
    #1 rst_n = 1'b1;
    tick;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_after: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_back_to_back;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(i % 5, 0, 32'd100 + 32'(i), 32'(i));
      tick;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.outreg1 !== 32'd100 + 32'(i) || bus.ctrl_command !== 4'(i % 5)) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b rdy=%b r1=%h cmd=%0d expected v=1 rdy=1 r1=%h cmd=%0d",
                 i, bus.out_valid, bus.in_ready, bus.outreg1, bus.ctrl_command, 32'd100 + 32'(i), i % 5);
      end
    end
    bus.in_valid = 1'b0;
    tick;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got v=%b expected 0", bus.out_valid); end
  endtask

  task automatic test_flush;
    bus.out_ready = 1'b0;
    drive(1, 0, 32'hA, 32'h0);
    tick;
    drive(1, 0, 32'hB, 32'h0);
    tick;
    checks++; if (bus.in_ready !== 1'b0 || bus.outreg1 !== 32'hA) begin errors++; $display("FAIL flush_setup: got rdy=%b r1=%h expected rdy=0 r1=a", bus.in_ready, bus.outreg1); end
    drive(1, 0, 32'hC, 32'h0);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_present[%0d]: got v=%b r1=%h expected v=0", i, bus.out_valid, bus.outreg1); end
    end
  endtask

  task automatic test_width64;
    b64.out_ready       = 1'b1;
    b64.in_valid        = 1'b1;
    b64.Op_from_control = 4'd2;
    b64.fonction        = 6'd0;
    b64.reg1            = 64'hFFFF_FFFF_0000_0001;
    b64.reg2            = 64'h8000_0000_0000_0002;
    tick;
    b64.in_valid = 1'b0;
    checks++;
    if (b64.out_valid !== 1'b1 || b64.outreg1 !== 64'hFFFF_FFFF_0000_0001 || b64.outreg2 !== 64'h8000_0000_0000_0002 || b64.ctrl_command !== 4'd2) begin
      errors++;
      $display("FAIL width64: got v=%b r1=%h r2=%h cmd=%0d expected v=1 r1=ffffffff00000001 r2=8000000000000002 cmd=2",
               b64.out_valid, b64.outreg1, b64.outreg2, b64.ctrl_command);
    end
    tick;
    checks++; if (b64.out_valid !== 1'b0) begin errors++; $display("FAIL width64_drain: got v=%b expected 0", b64.out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    bus.in_valid = 1'b0; bus.Op_from_control = '0; bus.fonction = '0;
    bus.reg1 = '0; bus.reg2 = '0; bus.out_ready = 1'b0;
    b64.in_valid = 1'b0; b64.Op_from_control = '0; b64.fonction = '0;
    b64.reg1 = '0; b64.reg2 = '0; b64.out_ready = 1'b0;

    test_reset;
    test_decode;
    test_back_pressure;
    test_reset_midstream;
    test_back_to_back;
    test_flush;
    test_width64;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Parametrised successor to the single-register ALU control stage. Sits between instruction decode and the ALU. Each accepted decode bundle (opcode, funct, two operands) becomes a registered ALU command plus operand pair. Unlike the previous generation, it decodes R-type funct fields, flags illegal encodings, supports valid/ready back-pressure through a two-entry skid buffer, and can be flushed on branch or exception.

## Interface
Parameters:
- DATA_W, 32, operand width.
- OP_W, 4, width of opcode from main control.
- CMD_W, 4, width of ALU command; must be ≥4.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous flush; drops all held entries.
- in_valid  in  1  decode bundle present.
- in_ready  out  1  stage can accept a bundle this cycle.
- Op_from_control  in  OP_W  main-control opcode.
- fonction  in  6  instruction funct field.
- reg1, reg2  in  DATA_W each  operands.
- out_valid  out  1  command bundle present.
- out_ready  in  1  ALU consumes the bundle this cycle.
- ctrl_command  out  CMD_W  ALU command.
- outreg1, outreg2  out  DATA_W each  registered operands.
- out_illegal  out  1  the bundle came from an unknown op/funct and was mapped to ADD.

## Operation
- Command codes: ADD=0, SUB=1, MUL=2, AND=3, OR=4, XOR=5, NOR=6, SLT=7, SLL=8, SRL=9.
- Op decode: opcodes 0–4 map to ADD, SUB, MUL, AND, OR respectively. Opcode 5 (RTYPE) selects the funct decode.
- Funct decode: 0x20→ADD, 0x22→SUB, 0x18→MUL, 0x24→AND, 0x25→OR, 0x26→XOR, 0x27→NOR, 0x2A→SLT, 0x00→SLL, 0x02→SRL.
- Illegal encodings: any other opcode, or RTYPE with any other funct, gives ADD with illegal=1.
- Decode is combinational on the input side. The result is captured with the operands as one entry of CMD_W+2·DATA_W+1 bits.
- Storage: output register (OUT) plus one skid register (SKID).
- FSM states:
  - EMPTY: nothing held.
  - ONE: OUT valid.
  - FULL: OUT and SKID valid.
- Transfer definitions: accept = in_valid & in_ready; consume = out_valid & out_ready.
- Transitions:
  - EMPTY: accept → load OUT, go to ONE.
  - ONE, accept & consume: load OUT, stay in ONE.
  - ONE, accept & no consume: load SKID, go to FULL.
  - ONE, consume only: go to EMPTY.
  - FULL, consume: OUT←SKID, go to ONE. No accept is possible because in_ready=0.
- Outputs derived from state: in_ready = (state≠FULL). out_valid = (state≠EMPTY).
- flush=1: next state is EMPTY regardless of accept/consume in the same cycle. Entries are discarded, not presented. Flush has priority over everything except reset.
- Operands pass through unmodified, with no width conversion.

## Timing
- Reset (async assert, sync release at the next edge):
  - State=EMPTY, so in_ready=1 and out_valid=0 during and after reset.
  - ctrl_command=0 (ADD), outreg1=outreg2=0, out_illegal=0, SKID cleared.
- Latency: an accept in cycle N gives out_valid=1 with that bundle in cycle N+1.
- Throughput: one bundle per cycle while out_ready=1.
- in_ready is registered (depends on state only), so there is no combinational ready path from out_ready.
- Ordering: bundles leave in accept order. SKID is always older than any new input.
- Data outputs hold stable while out_valid=1 and out_ready=0.
- Data outputs are don't-care when out_valid=0 but must not be X after reset.

## Test plan
- Reset mid-stream: FULL with out_ready=0, pulse rst_n low asynchronously between edges → out_valid=0, in_ready=1, ctrl_command=0 immediately, before the next edge.
- Decode sweep, out_ready=1:
  - Opcodes 0–4 give commands 0–4.
  - RTYPE with each listed funct gives the mapped command.
  - Opcode 5 with funct 0x3F → cmd 0, illegal=1.
  - Opcode 9 → cmd 0, illegal=1.
  - Every result appears one cycle after accept.
- Back-pressure: stream bundles A,B,C with reg1=1,2,3 and out_ready=0 from cycle 2 → state FULL, in_ready=0, C held upstream. Raise out_ready → outputs A,B,C in order, none lost or duplicated.
- Simultaneous accept and consume in ONE: continuous stream of 8 bundles, out_ready=1 → one output per cycle, in_ready stays 1.
- Flush: FULL (A in OUT, B in SKID), flush=1 with in_valid=1 (C) and out_ready=1 → next cycle EMPTY, out_valid=0; A, B and C are never presented.
- Width parameter: DATA_W=64, reg1=0xFFFF_FFFF_0000_0001 → outreg1 matches exactly one cycle after accept.
